// File: rtl/random_roller.sv
// rtl/random_roller.sv - dice-roll generator with doubling publish interval; ROLLER_HISTORY_EN adds o_prev_out
module random_roller #(
  parameter int                LFSR_W          = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED            = 16'hACE1,
  parameter int                OUT_W           = 4,
  parameter int                RANGE           = 16,
  parameter int                BASE_INTERVAL   = 2_500_000,
  parameter int                NUM_STAGES      = 5,
  parameter int                STEPS_PER_STAGE = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic                              i_stop,
  output logic [OUT_W-1:0]                  o_random_out,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [$clog2(NUM_STAGES+1)-1:0]   o_stage
`ifdef ROLLER_HISTORY_EN
  ,
  output logic [OUT_W-1:0]                  o_prev_out
`endif
);

  localparam int STAGE_W      = $clog2(NUM_STAGES + 1);
  localparam int STEP_W       = $clog2(STEPS_PER_STAGE + 1);
  localparam int MAX_INTERVAL = BASE_INTERVAL << (NUM_STAGES - 1);
  localparam int CNT_W        = (MAX_INTERVAL > 1) ? $clog2(MAX_INTERVAL) : 1;

  localparam logic [CNT_W-1:0] BASE_LIMIT = CNT_W'(BASE_INTERVAL - 1);
  localparam logic [OUT_W:0]   RANGE_V    = (OUT_W + 1)'(RANGE);

  typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [LFSR_W-1:0]  lfsr;
  logic [CNT_W-1:0]   cnt;
  // limit holds interval-1, so doubling the interval is a shift with a 1 shifted in
  logic [CNT_W-1:0]   limit;
  logic [STEP_W-1:0]  step;
  logic [STAGE_W-1:0] stage;
  logic [OUT_W-1:0]   candidate;
  logic               cand_ok;
  logic               at_limit;
  logic               last_step;
  logic               last_stage;
  logic               init;
  logic               publish;
  logic               cnt_inc;

  assign candidate  = lfsr[OUT_W-1:0];
  assign cand_ok    = {1'b0, candidate} < RANGE_V;
  assign at_limit   = (cnt == limit);
  assign last_step  = (step == STEP_W'(STEPS_PER_STAGE - 1));
  assign last_stage = (stage == STAGE_W'(NUM_STAGES - 1));

  assign o_busy  = (state == ROLL);
  assign o_done  = (state == DONE);
  assign o_stage = stage;

  // free-running Galois LFSR, only held by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next state and datapath control; start beats stop, both beat a publish
  always_comb begin
    next_state = state;
    init       = 1'b0;
    publish    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          next_state = ROLL;
          init       = 1'b1;
        end
      end
      ROLL: begin
        if (i_start) begin
          init = 1'b1;
        end else if (i_stop) begin
          next_state = DONE;
        end else if (at_limit) begin
          if (cand_ok) begin
            publish = 1'b1;
            if (last_step && last_stage) begin
              next_state = DONE;
            end
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (i_start) begin
          next_state = ROLL;
          init       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // roll pacing counters and published value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      limit        <= BASE_LIMIT;
      step         <= '0;
      stage        <= '0;
      o_random_out <= '0;
    end else if (init) begin
      cnt   <= '0;
      limit <= BASE_LIMIT;
      step  <= '0;
      stage <= '0;
    end else if (publish) begin
      o_random_out <= candidate;
      cnt          <= '0;
      if (last_step) begin
        step  <= '0;
        stage <= stage + STAGE_W'(1);
        limit <= (limit << 1) | CNT_W'(1);
      end else begin
        step <= step + STEP_W'(1);
      end
    end else if (cnt_inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef ROLLER_HISTORY_EN
  logic [OUT_W-1:0] final_out;

  // final_out tracks the last roll's result; it is copied out before being refreshed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      final_out  <= '0;
      o_prev_out <= '0;
    end else begin
      if (next_state == DONE) begin
        o_prev_out <= final_out;
      end
      if (state == DONE) begin
        final_out <= o_random_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_random_roller.sv
// tb/tb_random_roller.sv - directed bench for random_roller; ROLLER_HISTORY_EN enables o_prev_out checks
module tb_random_roller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] out;
  logic       busy;
  logic       done;
  logic [1:0] stage;
`ifdef ROLLER_HISTORY_EN
  logic [3:0] prev;
`endif

  int checks;
  int errors;
  int ecount;
  int done_seen;

  random_roller #(
    .LFSR_W(8), .LFSR_TAPS(8'hB8), .SEED(8'h01), .OUT_W(4), .RANGE(10),
    .BASE_INTERVAL(4), .NUM_STAGES(2), .STEPS_PER_STAGE(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_stop(stop),
    .o_random_out(out),
    .o_busy(busy),
    .o_done(done),
    .o_stage(stage)
`ifdef ROLLER_HISTORY_EN
    ,
    .o_prev_out(prev)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ecount++;
  endtask

  task automatic wait_until(input int e);
    while (ecount < e) tick();
  endtask

  // ecount counts edges since the last reset edge; LFSR value after edge n is step n from SEED
  task automatic apply_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    ecount = 0;
  endtask

  task automatic snap(input string tag, input int e, input int o, input int b, input int d, input int s);
    wait_until(e);
    check({tag, ".out"},   32'(out),   o);
    check({tag, ".busy"},  32'(busy),  b);
    check({tag, ".done"},  32'(done),  d);
    check({tag, ".stage"}, 32'(stage), s);
  endtask

  task automatic pulse_start(input int e);
    wait_until(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop(input int e);
    wait_until(e);
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // candidates (low nibble of LFSR before edge n): n=5:7 9:4 17:3 25:3; second roll 35..37 rejected B,D,E, 38:7 42:2 50,51 rejected A,D, 52:6 60:6
  task automatic run_natural(input string p);
    pulse_start(0);
    snap({p, "_e1"},  1,  0, 1, 0, 0);
    snap({p, "_e4"},  4,  0, 1, 0, 0);
    snap({p, "_e5"},  5,  7, 1, 0, 0);
    snap({p, "_e8"},  8,  7, 1, 0, 0);
    snap({p, "_e9"},  9,  4, 1, 0, 1);
    snap({p, "_e16"}, 16, 4, 1, 0, 1);
    snap({p, "_e17"}, 17, 3, 1, 0, 1);
    snap({p, "_e24"}, 24, 3, 1, 0, 1);
    snap({p, "_e25"}, 25, 3, 0, 1, 2);
`ifdef ROLLER_HISTORY_EN
    check({p, "_e25.prev"}, 32'(prev), 0);
`endif
    snap({p, "_e26"}, 26, 3, 0, 0, 2);
    snap({p, "_e30"}, 30, 3, 0, 0, 2);
    pulse_start(30);
    snap({p, "_e37"}, 37, 3, 1, 0, 0);
    snap({p, "_e38"}, 38, 7, 1, 0, 0);
    snap({p, "_e42"}, 42, 2, 1, 0, 1);
    snap({p, "_e51"}, 51, 2, 1, 0, 1);
    snap({p, "_e52"}, 52, 6, 1, 0, 1);
    snap({p, "_e59"}, 59, 6, 1, 0, 1);
    snap({p, "_e60"}, 60, 6, 0, 1, 2);
`ifdef ROLLER_HISTORY_EN
    check({p, "_e60.prev"}, 32'(prev), 3);
`endif
    snap({p, "_e61"}, 61, 6, 0, 0, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog ecount=%0d", ecount);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    ecount    = 0;
    done_seen = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;

    // reset and idle
    apply_reset();
    snap("idle_e0", 0, 0, 0, 0, 0);
`ifdef ROLLER_HISTORY_EN
    check("idle_e0.prev", 32'(prev), 0);
`endif
    repeat (100) begin
      tick();
      if (done) done_seen++;
    end
    check("idle.done_seen", 32'(done_seen), 0);
    snap("idle_e100", 100, 0, 0, 0, 0);

    // two natural rolls from power-on sequence
    apply_reset();
    run_natural("nat");

    // start at edge 9: rejections at 13,14,15 and 36,37; value 0 published at 20
    apply_reset();
    pulse_start(8);
    snap("rej_e15", 15, 0, 1, 0, 0);
    snap("rej_e16", 16, 7, 1, 0, 0);
    snap("rej_e19", 19, 7, 1, 0, 0);
    snap("rej_e20", 20, 0, 1, 0, 1);
    snap("rej_e27", 27, 0, 1, 0, 1);
    snap("rej_e28", 28, 2, 1, 0, 1);
    snap("rej_e37", 37, 2, 1, 0, 1);
    snap("rej_e38", 38, 7, 0, 1, 2);
    snap("rej_e39", 39, 7, 0, 0, 2);

    // early stop at k+6, then stop while idle is ignored
    apply_reset();
    pulse_start(0);
    snap("stop_e5", 5, 7, 1, 0, 0);
    pulse_stop(6);
    snap("stop_e7", 7, 7, 0, 1, 0);
    snap("stop_e8", 8, 7, 0, 0, 0);
    snap("stop_e12", 12, 7, 0, 0, 0);
    pulse_stop(12);
    snap("stop_e13", 13, 7, 0, 0, 0);

    // restart at k+10: publish at 15 rejected (E), 16 publishes 7
    apply_reset();
    pulse_start(0);
    snap("rst_e9", 9, 4, 1, 0, 1);
    pulse_start(10);
    snap("restart_e11", 11, 4, 1, 0, 0);
    snap("restart_e15", 15, 4, 1, 0, 0);
    snap("restart_e16", 16, 7, 1, 0, 0);
    snap("restart_e20", 20, 0, 1, 0, 1);

    // start and stop together: restart wins, next publish 9 at edge 11
    apply_reset();
    pulse_start(0);
    wait_until(6);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    snap("both_e7", 7, 7, 1, 0, 0);
    snap("both_e10", 10, 7, 1, 0, 0);
    snap("both_e11", 11, 9, 1, 0, 0);

    // start during DONE restarts; the done pulse still occurs
    apply_reset();
    pulse_start(0);
    snap("dstart_e25", 25, 3, 0, 1, 2);
    pulse_start(25);
    snap("dstart_e26", 26, 3, 1, 0, 0);
    snap("dstart_e29", 29, 3, 1, 0, 0);
    snap("dstart_e30", 30, 4, 1, 0, 0);

    // reset mid-roll, then the sequence must replay as after power-on
    apply_reset();
    pulse_start(0);
    wait_until(6);
    rst = 1'b1;
    tick();
    snap("midrst_e7", 7, 0, 0, 0, 0);
`ifdef ROLLER_HISTORY_EN
    check("midrst_e7.prev", 32'(prev), 0);
`endif
    rst    = 1'b0;
    ecount = 0;
    run_natural("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
